// File: rtl/signed_display_pkg.sv
// signed_display_pkg: segment constants, sequencer state encoding and the
// magnitude-digit pattern lookup shared by the display sequencer files.
package signed_display_pkg;

  // All segments off (active-low display).
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  // Only segment g lit: the minus sign.
  localparam logic [6:0] SEG_MINUS = 7'b1111110;

  // Digit selector values for the scan.
  localparam logic DIGIT_MAG  = 1'b0;
  localparam logic DIGIT_SIGN = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    HOLD = 2'd2
  } state_e;

  // Active-low {a..g} pattern for the magnitude of a 4-bit two's-complement value.
  // -8 has magnitude 8 and is shown with every segment lit.
  function automatic logic [6:0] mag_pattern(input logic [3:0] value);
    logic [3:0] mag;
    mag = value[3] ? (4'd0 - value) : value;
    case (mag)
      4'd0:    mag_pattern = 7'b0000001;
      4'd1:    mag_pattern = 7'b1001111;
      4'd2:    mag_pattern = 7'b0010010;
      4'd3:    mag_pattern = 7'b0000110;
      4'd4:    mag_pattern = 7'b1001100;
      4'd5:    mag_pattern = 7'b0100100;
      4'd6:    mag_pattern = 7'b0100000;
      4'd7:    mag_pattern = 7'b0001111;
      4'd8:    mag_pattern = 7'b0000000;
      default: mag_pattern = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/signed_seg_decode.sv
// signed_seg_decode: combinational sign/magnitude segment decode of a 4-bit
// two's-complement value for a two-digit active-low display.
module signed_seg_decode
  import signed_display_pkg::*;
(
  input  logic [3:0] i_value,
  output logic [6:0] o_mag_seg,
  output logic [6:0] o_sign_seg
);

  // Magnitude pattern from the shared table; minus sign whenever bit 3 is set.
  always_comb begin
    o_mag_seg  = mag_pattern(i_value);
    o_sign_seg = i_value[3] ? SEG_MINUS : SEG_BLANK;
  end

endmodule

// File: rtl/signed_display_sequencer.sv
// signed_display_sequencer: cycles a two-digit seven-segment display through
// NUM_SLOTS stored signed values, scanning sign and magnitude digits.
// Optional build macro SIGNED_DISPLAY_SKIP_ZERO_EN: dwell advances and start
// skip slots that hold zero.
module signed_display_sequencer
  import signed_display_pkg::*;
#(
  parameter int NUM_SLOTS    = 4,
  parameter int DWELL_CYCLES = 50000000,
  parameter int SCAN_CYCLES  = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic       start,
  input  logic       pause,
  input  logic       stop,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic [3:0] slot_idx,
  output logic       busy
);

  localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_CYCLES - 1);
  localparam logic [3:0]    SLOT_LAST  = 4'(NUM_SLOTS - 1);

  state_e        r_state;
  state_e        w_state_nxt;
  logic [3:0]    r_slots [NUM_SLOTS];
  logic [3:0]    r_slot_idx;
  logic [DW-1:0] r_dwell;
  logic [SW-1:0] r_scan;
  logic          r_digit;
  logic [6:0]    r_seg;
  logic [1:0]    r_an;
  logic          r_busy;

  logic [3:0]    w_sel_value;
  logic [6:0]    w_mag_seg;
  logic [6:0]    w_sign_seg;
  logic [3:0]    w_adv_idx;
  logic [3:0]    w_start_idx;
  logic [6:0]    w_seg_nxt;
  logic [1:0]    w_an_nxt;
  logic          w_dwell_wrap;

  assign seg      = r_seg;
  assign an       = r_an;
  assign slot_idx = r_slot_idx;
  assign busy     = r_busy;

  assign w_dwell_wrap = (r_dwell == DWELL_LAST);

  // Slot storage: writes land on the clock edge in any state; out-of-range addresses match no slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_slots[i] <= 4'd0;
      end
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (wr_en && (wr_addr == 4'(i))) begin
          r_slots[i] <= wr_data;
        end
      end
    end
  end

  // Select the value of the slot currently on display.
  always_comb begin
    w_sel_value = 4'd0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_sel_value = (r_slot_idx == 4'(i)) ? r_slots[i] : w_sel_value;
    end
  end

  signed_seg_decode u_decode (
    .i_value    (w_sel_value),
    .o_mag_seg  (w_mag_seg),
    .o_sign_seg (w_sign_seg)
  );

`ifdef SIGNED_DISPLAY_SKIP_ZERO_EN
  logic [NUM_SLOTS-1:0] w_nonzero;
  logic [4:0]           w_dist;
  logic [4:0]           w_best;

  // Flag each slot that holds a nonzero value.
  always_comb begin
    w_nonzero = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_nonzero[i] = (r_slots[i] != 4'd0);
    end
  end

  // Nearest nonzero slot after the current one with wrap; the current slot is the last candidate.
  always_comb begin
    w_adv_idx = r_slot_idx;
    w_best    = 5'd31;
    w_dist    = 5'd0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_dist    = (5'(i) > {1'b0, r_slot_idx}) ? (5'(i) - {1'b0, r_slot_idx})
                                               : (5'(i) + 5'(NUM_SLOTS) - {1'b0, r_slot_idx});
      w_adv_idx = (w_nonzero[i] && (w_dist < w_best)) ? 4'(i) : w_adv_idx;
      w_best    = (w_nonzero[i] && (w_dist < w_best)) ? w_dist : w_best;
    end
  end

  // Lowest-index nonzero slot for start; slot 0 when all slots are zero.
  always_comb begin
    w_start_idx = 4'd0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      w_start_idx = w_nonzero[i] ? 4'(i) : w_start_idx;
    end
  end
`else
  // Plain in-order advance with wrap; start always begins at slot 0.
  always_comb begin
    w_adv_idx   = (r_slot_idx == SLOT_LAST) ? 4'd0 : (r_slot_idx + 4'd1);
    w_start_idx = 4'd0;
  end
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: stop beats start, start beats pause (start is a no-op in SHOW).
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (stop) begin
          w_state_nxt = IDLE;
        end else if (start) begin
          w_state_nxt = SHOW;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SHOW: begin
        if (stop) begin
          w_state_nxt = IDLE;
        end else if (start) begin
          w_state_nxt = SHOW;
        end else if (pause) begin
          w_state_nxt = HOLD;
        end else begin
          w_state_nxt = SHOW;
        end
      end
      HOLD: begin
        if (stop) begin
          w_state_nxt = IDLE;
        end else if (start || pause) begin
          w_state_nxt = SHOW;
        end else begin
          w_state_nxt = HOLD;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Dwell/slot and scan counters: dwell runs only in SHOW, scan in SHOW and HOLD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot_idx <= 4'd0;
      r_dwell    <= '0;
      r_scan     <= '0;
      r_digit    <= DIGIT_MAG;
    end else begin
      case (r_state)
        SHOW, HOLD: begin
          if (stop) begin
            r_slot_idx <= 4'd0;
            r_dwell    <= '0;
            r_scan     <= '0;
            r_digit    <= DIGIT_MAG;
          end else begin
            if (r_state == SHOW) begin
              if (w_dwell_wrap) begin
                r_dwell    <= '0;
                r_slot_idx <= w_adv_idx;
              end else begin
                r_dwell <= r_dwell + DW'(1);
              end
            end
            if (r_scan == SCAN_LAST) begin
              r_scan  <= '0;
              r_digit <= ~r_digit;
            end else begin
              r_scan <= r_scan + SW'(1);
            end
          end
        end
        default: begin
          r_dwell    <= '0;
          r_scan     <= '0;
          r_digit    <= DIGIT_MAG;
          r_slot_idx <= (w_state_nxt == SHOW) ? w_start_idx : 4'd0;
        end
      endcase
    end
  end

  // FSM outputs: blank in IDLE, otherwise drive the digit chosen by the scan.
  always_comb begin
    w_seg_nxt = SEG_BLANK;
    w_an_nxt  = 2'b11;
    case (r_state)
      SHOW, HOLD: begin
        if (r_digit == DIGIT_MAG) begin
          w_seg_nxt = w_mag_seg;
          w_an_nxt  = 2'b10;
        end else begin
          w_seg_nxt = w_sign_seg;
          w_an_nxt  = 2'b01;
        end
      end
      default: begin
        w_seg_nxt = SEG_BLANK;
        w_an_nxt  = 2'b11;
      end
    endcase
  end

  // Registered pin outputs; busy follows the state register without extra lag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg  <= SEG_BLANK;
      r_an   <= 2'b11;
      r_busy <= 1'b0;
    end else begin
      r_seg  <= w_seg_nxt;
      r_an   <= w_an_nxt;
      r_busy <= (w_state_nxt != IDLE);
    end
  end

endmodule
